// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Multi-port register file with a per-register pending (busy) scoreboard.
//   Sits between issue and writeback: NR combinational read ports feed operand
//   fetch, NW write ports retire results, and the busy bits flag registers
//   whose producer has issued but not yet written back.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : write-through forwarding from the write ports to the read
//                 ports in the same cycle (combinational we/wdata -> rdata).
//     undefined : reads reflect stored state only.
//
// Parameters
//   DW        data width
//   AW        address width, depth = 2**AW
//   NR        number of read ports  (>= 1)
//   NW        number of write ports (>= 1)
//   ZERO_REG  1: register 0 reads 0, ignores writes and issue, never busy
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous reset, active-low
//   raddr     NR*AW  read addresses, port i = raddr[i*AW +: AW]
//   rdata     NR*DW  read data,     port i = rdata[i*DW +: DW]
//   rbusy     NR     busy bit of the register addressed by read port i
//   we        NW     write enables
//   waddr     NW*AW  write addresses, port j = waddr[j*AW +: AW]
//   wdata     NW*DW  write data,      port j = wdata[j*DW +: DW]
//   iss_vld   1      issue strobe: mark iss_addr pending
//   iss_addr  AW     destination register of the issued instruction

module regfile_mp_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic             iss_vld,
    input  logic [AW-1:0]    iss_addr
);

    localparam int DEPTH = 1 << AW;

    // Registers that are hard-wired and must never take a write or issue.
    localparam logic [DEPTH-1:0] HARD_MASK =
        {{(DEPTH-1){1'b0}}, (ZERO_REG != 0)};

    logic [DW-1:0]    mem    [DEPTH];
    logic [DEPTH-1:0] busy;

    logic [DEPTH-1:0] wr_hit;
    logic [DW-1:0]    wr_val [DEPTH];
    logic [DEPTH-1:0] iss_hit;

    // Write / issue address decode. Ports are scanned in ascending order so
    // the highest-index port that hits a register supplies its data.
    always_comb begin
        wr_hit  = '0;
        iss_hit = '0;
        for (int r = 0; r < DEPTH; r++) begin
            wr_val[r] = '0;
            for (int j = 0; j < NW; j++) begin
                if (we[j] && (waddr[j*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdata[j*DW +: DW];
                end
            end
            iss_hit[r] = iss_vld && (iss_addr == AW'(r));
        end
    end

    // Storage and scoreboard. A same-edge issue beats a write-back clear:
    // the newly issued instruction is the outstanding producer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (!HARD_MASK[r]) begin
                    if (wr_hit[r]) begin
                        mem[r] <= wr_val[r];
                    end
                    if (iss_hit[r]) begin
                        busy[r] <= 1'b1;
                    end else if (wr_hit[r]) begin
                        busy[r] <= 1'b0;
                    end
                end
            end
        end
    end

    // Read ports, 0-cycle latency.
    always_comb begin
        logic [AW-1:0] ra;
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NR; i++) begin
            ra                = raddr[i*AW +: AW];
            rdata[i*DW +: DW] = mem[ra];
            rbusy[i]          = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; the register is only still
            // pending if a new producer issues to it in this same cycle.
            for (int j = 0; j < NW; j++) begin
                if (we[j] && (waddr[j*AW +: AW] == ra)) begin
                    rdata[i*DW +: DW] = wdata[j*DW +: DW];
                    rbusy[i]          = iss_vld && (iss_addr == ra);
                end
            end
`endif
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rdata[i*DW +: DW] = '0;
                rbusy[i]          = 1'b0;
            end
        end
    end

endmodule
